// File: rtl/shift_pack_sequencer.sv
// Shift-register sequencer/packer: collects Depth words of DataWidth bits into one wide output group.
// Optional SHIFT_PACK_STALL_CNT_EN adds a saturating stall_cnt output counting held-output cycles.
module shift_pack_sequencer #(
  parameter int DataWidth = 8,
  parameter int Depth     = 4,
  parameter int CntWidth  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DataWidth-1:0]       in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DataWidth*Depth-1:0] out_data,
  output logic [CntWidth-1:0]        out_count,
  output logic                       sr_en
`ifdef SHIFT_PACK_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_PAD  = 1'b1;
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

  // Handshakes: a word moves on in_valid && in_ready; a group moves on out_valid && out_ready.
  logic [0:0]                 state;
  logic [CntWidth-1:0]        count;
  logic [CntWidth-1:0]        real_count;
  logic [DataWidth*Depth-1:0] storage;

  logic                       out_busy;
  logic                       completes_fill;
  logic                       accept;
  logic                       pad_final;
  logic                       pad_shift;
  logic                       load;
  logic [DataWidth-1:0]       shift_word;
  logic [DataWidth*Depth-1:0] shifted;

  always_comb begin
    out_busy       = out_valid && !out_ready;
    completes_fill = (count == LastIdx) || in_last;
    in_ready       = rst && (state == ST_FILL) && !(completes_fill && out_busy);
    accept         = in_valid && in_ready;
    // In PAD, count is the number of shifts already done for this group.
    pad_final      = (state == ST_PAD) && (count == LastIdx);
    pad_shift      = (state == ST_PAD) && !(pad_final && out_busy);
    sr_en          = accept || pad_shift;
    load           = (accept && (count == LastIdx)) || (pad_shift && pad_final);
    shift_word     = accept ? in_data : '0;
    shifted        = {storage[DataWidth*(Depth-1)-1:0], shift_word};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_FILL;
      count      <= '0;
      real_count <= '0;
      storage    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
    end else begin
      if (sr_en) storage <= shifted;

      if (state == ST_FILL) begin
        if (accept) begin
          if (count == LastIdx) begin
            count     <= '0;
            out_data  <= shifted;
            out_count <= FullCnt;
          end else begin
            count <= count + 1'b1;
            if (in_last) begin
              real_count <= count + 1'b1;
              state      <= ST_PAD;
            end
          end
        end
      end else if (pad_shift) begin
        if (pad_final) begin
          count     <= '0;
          state     <= ST_FILL;
          out_data  <= shifted;
          out_count <= real_count;
        end else begin
          count <= count + 1'b1;
        end
      end

      if (load) out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

`ifdef SHIFT_PACK_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else if (out_busy && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
  end
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_shift_pack_sequencer.sv
// Directed self-checking bench for shift_pack_sequencer (DataWidth=8, Depth=4).
module tb_shift_pack_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        sr_en;
`ifdef SHIFT_PACK_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  shift_pack_sequencer #(.DataWidth(8), .Depth(4), .CntWidth(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .sr_en     (sr_en)
`ifdef SHIFT_PACK_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got=%h exp=00000000", out_data); end
    checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL rst_out_count got=%0d exp=0", out_count); end
    checks++; if (sr_en !== 1'b0) begin errors++; $display("FAIL rst_sr_en got=%0b exp=0", sr_en); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_after got=%0b exp=1", in_ready); end
  endtask

  task automatic test_full_group();
    logic [7:0] w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      #1;
      checks++; if (sr_en !== 1'b1) begin errors++; $display("FAIL full_sr_en[%0d] got=%0b exp=1", i, sr_en); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_pre_valid[%0d] got=%0b exp=0", i, out_valid); end
      cyc();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got=%0b exp=1", out_valid); end
    checks++; if (out_data !== 32'h11223344) begin errors++; $display("FAIL full_data got=%h exp=11223344", out_data); end
    checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", out_count); end
    checks++; if (sr_en !== 1'b0) begin errors++; $display("FAIL idle_sr_en got=%0b exp=0", sr_en); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_unload got=%0b exp=0", out_valid); end
  endtask

  task automatic test_last_pad();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0;
    cyc();
    in_data = 8'hBB; in_last = 1'b1;
    cyc();
    in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pad_in_ready[%0d] got=%0b exp=0", i, in_ready); end
      checks++; if (sr_en !== 1'b1) begin errors++; $display("FAIL pad_sr_en[%0d] got=%0b exp=1", i, sr_en); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pad_valid[%0d] got=%0b exp=0", i, out_valid); end
      cyc();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pad_out_valid got=%0b exp=1", out_valid); end
    checks++; if (out_data !== 32'hAABB0000) begin errors++; $display("FAIL pad_data got=%h exp=AABB0000", out_data); end
    checks++; if (out_count !== 3'd2) begin errors++; $display("FAIL pad_count got=%0d exp=2", out_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pad_fill_resume got=%0b exp=1", in_ready); end
    cyc();
  endtask

  task automatic test_stall();
    logic [7:0] g1 [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    logic [7:0] g2 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = g1[i];
      cyc();
    end
    checks++; if (out_data !== 32'hA1A2A3A4) begin errors++; $display("FAIL stall_g1 got=%h exp=A1A2A3A4", out_data); end
    for (int i = 0; i < 3; i++) begin
      in_data = g2[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept[%0d] got=%0b exp=1", i, in_ready); end
      cyc();
    end
    in_data = g2[3];
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_block got=%0b exp=0", in_ready); end
    checks++; if (sr_en !== 1'b0) begin errors++; $display("FAIL stall_sr_en got=%0b exp=0", sr_en); end
    cyc();
    checks++; if (out_data !== 32'hA1A2A3A4) begin errors++; $display("FAIL stall_hold got=%h exp=A1A2A3A4", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid got=%0b exp=1", out_valid); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got=%0b exp=1", in_ready); end
    cyc();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_nobubble got=%0b exp=1", out_valid); end
    checks++; if (out_data !== 32'h01020304) begin errors++; $display("FAIL stall_g2 got=%h exp=01020304", out_data); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data;
    logic        exp_valid;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1);
      cyc();
      exp_valid = (i == 3) || (i == 7);
      exp_data  = (i < 4) ? 32'h01020304 : 32'h05060708;
      checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL b2b_valid[%0d] got=%0b exp=%0b", i, out_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (out_data !== exp_data) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, out_data, exp_data); end
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; cyc();
    in_data = 8'h22; cyc();
    in_data = 8'h33;
    #1 rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mrst_in_ready got=%0b exp=0", in_ready); end
    checks++; if (sr_en !== 1'b0) begin errors++; $display("FAIL mrst_sr_en got=%0b exp=0", sr_en); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mrst_data got=%h exp=00000000", out_data); end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    cyc();
    in_valid = 1'b1; in_data = 8'hAA; cyc();
    in_data = 8'hBB; in_last = 1'b1; cyc();
    in_valid = 1'b0; in_last = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++; if (sr_en !== 1'b0) begin errors++; $display("FAIL prst_sr_en got=%0b exp=0", sr_en); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prst_valid got=%0b exp=0", out_valid); end
    #1 rst = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'h5A + 8'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clean_ready[%0d] got=%0b exp=1", i, in_ready); end
      cyc();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clean_valid got=%0b exp=1", out_valid); end
    checks++; if (out_data !== 32'h5A5B5C5D) begin errors++; $display("FAIL clean_data got=%h exp=5A5B5C5D", out_data); end
    checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL clean_count got=%0d exp=4", out_count); end
    cyc();
  endtask

`ifdef SHIFT_PACK_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL scnt_reset got=%0d exp=0", stall_cnt); end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(i); cyc();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL scnt_ten got=%0d exp=10", stall_cnt); end
    force dut.stall_cnt = 16'hFFFD;
    cyc();
    release dut.stall_cnt;
    for (int i = 0; i < 4; i++) cyc();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL scnt_sat got=%h exp=FFFF", stall_cnt); end
    out_ready = 1'b1;
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_full_group();
    test_last_pad();
    test_stall();
    test_back_to_back();
    test_mid_reset();
`ifdef SHIFT_PACK_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
